// File: rtl/kypd_pkg.sv
// Shared types and helpers for the PmodKYPD keypad scanner.
package kypd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  // Result of one full four-column scan; none=1 means no row was low.
  typedef struct packed {
    logic       none;
    logic [3:0] key;
  } scan_res_t;

  localparam scan_res_t SCAN_NONE = '{none: 1'b1, key: 4'h0};

  // PmodKYPD layout: {row,col} -> hex code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// Column driver: row synchronizer, dwell counter, column rotation and per-scan result.
module kypd_col_scan
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 8192
) (
  input  logic      CLK,
  input  logic      RSTN,
  input  logic [3:0] ROW_I,
  output logic [3:0] col,
  output logic      scan_vld,
  output scan_res_t scan_res
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          found;
  logic [3:0]    found_key;

  logic          dwell_tc;
  logic [1:0]    first_row;
  logic          acc_found;
  logic [3:0]    acc_key;

  // Lowest-numbered low row of the current column, merged with earlier columns of this scan.
  always_comb begin
    dwell_tc  = (dwell == DW'(SCAN_DIV - 1));
    first_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2[i]) first_row = 2'(i);
    end
    acc_found = found | (row_s2 != 4'hF);
    acc_key   = found ? found_key : key_map(first_row, col_idx);
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= ROW_I;
      row_s2 <= row_s1;
    end
  end

  // Dwell count, column rotation and first-hit accumulation across col0..col3.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      dwell     <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      found     <= 1'b0;
      found_key <= 4'h0;
      scan_vld  <= 1'b0;
      scan_res  <= SCAN_NONE;
    end else begin
      scan_vld <= 1'b0;
      if (dwell_tc) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx == 2'd3) begin
          scan_vld      <= 1'b1;
          scan_res.none <= ~acc_found;
          scan_res.key  <= acc_found ? acc_key : 4'h0;
          found         <= 1'b0;
          found_key     <= 4'h0;
        end else begin
          found     <= acc_found;
          found_key <= acc_key;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

endmodule

// File: rtl/kypd_scanner.sv
// Keypad scanner top: debounce FSM, last-key and 8-digit entry registers.
// Optional: define KYPD_CLEAR_EN so an accepted 'C' clears the entry register.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 8192,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [3:0]  ROW_I,
  output logic [3:0]  COL_O,
  output logic [3:0]  KEY_O,
  output logic        KEY_VLD_O,
  output logic [31:0] ENTRY_O
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx;
  logic [CW-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
  logic          accept;
  logic [3:0]    key_nx;
  logic [31:0]   entry_nx;

  logic          scan_vld;
  scan_res_t     scan_res;

  kypd_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .ROW_I    (ROW_I),
    .col      (COL_O),
    .scan_vld (scan_vld),
    .scan_res (scan_res)
  );

  // Debounce FSM, advanced once per scan result; acceptance updates key and entry.
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    rcnt_nx  = rcnt;
    accept   = 1'b0;
    key_nx   = KEY_O;
    entry_nx = ENTRY_O;

    if (scan_vld) begin
      case (state)
        ST_IDLE: begin
          if (!scan_res.none) begin
            state_nx = ST_DEBOUNCE;
            cand_nx  = scan_res.key;
            cnt_nx   = CW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (scan_res.none) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else if (scan_res.key == cand) begin
            cnt_nx = cnt + CW'(1);
          end else begin
            cand_nx = scan_res.key;
            cnt_nx  = CW'(1);
          end
        end
        ST_PRESSED: begin
          if (scan_res.none) begin
            if (rcnt + CW'(1) == CNT_DONE) begin
              state_nx = ST_IDLE;
              rcnt_nx  = '0;
            end else begin
              rcnt_nx = rcnt + CW'(1);
            end
          end else begin
            rcnt_nx = '0;
          end
        end
        default: state_nx = ST_IDLE;
      endcase

      if (state_nx == ST_DEBOUNCE && cnt_nx == CNT_DONE) begin
        accept   = 1'b1;
        state_nx = ST_PRESSED;
        cnt_nx   = '0;
        rcnt_nx  = '0;
      end
    end

    if (accept) begin
      key_nx   = cand_nx;
`ifdef KYPD_CLEAR_EN
      if (cand_nx == 4'hC) entry_nx = 32'h0;
      else                 entry_nx = {ENTRY_O[27:0], cand_nx};
`else
      entry_nx = {ENTRY_O[27:0], cand_nx};
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      cand      <= 4'h0;
      cnt       <= '0;
      rcnt      <= '0;
      KEY_O     <= 4'h0;
      KEY_VLD_O <= 1'b0;
      ENTRY_O   <= 32'h0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      rcnt      <= rcnt_nx;
      KEY_O     <= key_nx;
      KEY_VLD_O <= accept;
      ENTRY_O   <= entry_nx;
    end
  end

endmodule

// File: tb/tb_kypd_scanner.sv
// Testbench for kypd_scanner: keypad model, press table and expected-report scoreboard.
module tb_kypd_scanner;
  import kypd_pkg::*;

  localparam int unsigned SCAN_DIV       = 4;
  localparam int unsigned DEBOUNCE_SCANS = 2;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [3:0]  ROW_I;
  logic [3:0]  COL_O;
  logic [3:0]  KEY_O;
  logic        KEY_VLD_O;
  logic [31:0] ENTRY_O;
  logic [15:0] keys_down = 16'h0;

  always #5 CLK = ~CLK;

  kypd_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .ROW_I     (ROW_I),
    .COL_O     (COL_O),
    .KEY_O     (KEY_O),
    .KEY_VLD_O (KEY_VLD_O),
    .ENTRY_O   (ENTRY_O)
  );

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    ROW_I = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !COL_O[c]) ROW_I[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] keys;
    int          hold;
    logic        exp_pulse;
    logic [3:0]  exp_key;
  } vec_t;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] entry;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  logic [3:0]  col_seq[4];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          vld_cyc = 0;
  int          seen = 0;
  int          expected = 0;
  int          rel = 0;
  logic [31:0] m_entry = 32'h0;
  logic [3:0]  m_key = 4'h0;

  function automatic logic [15:0] kb(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge; every pulse is checked against the scoreboard.
  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (KEY_VLD_O === 1'b1) begin
        seen++;
        vld_cyc = cyc;
        if (sb.size() == 0) begin
          chk("spurious_vld", 32'(KEY_VLD_O), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("vld_key", 32'(KEY_O), 32'(e.key));
          chk("vld_entry", ENTRY_O, e.entry);
        end
      end
    end
  endtask

  task automatic expect_key(input logic [3:0] k);
    m_key = k;
`ifdef KYPD_CLEAR_EN
    if (k == 4'hC) m_entry = 32'h0;
    else           m_entry = {m_entry[27:0], k};
`else
    m_entry = {m_entry[27:0], k};
`endif
    sb.push_back('{key: k, entry: m_entry});
    expected++;
  endtask

  task automatic settle_checks();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    sb.delete();
    chk("fsm_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("key_held", 32'(KEY_O), 32'(m_key));
    chk("entry_held", ENTRY_O, m_entry);
  endtask

  task automatic run_vec(input vec_t v);
    if (v.exp_pulse) expect_key(v.exp_key);
    keys_down = v.keys;
    tick(v.hold);
    keys_down = 16'h0;
    tick(56);
    settle_checks();
  endtask

  initial begin
    vecs[0] = '{kb(1, 1), 48, 1'b1, 4'h5};
    for (int d = 1; d <= 9; d++)
      vecs[d] = '{kb((d - 1) / 3, (d - 1) % 3), 48, 1'b1, 4'(d)};
    vecs[10] = '{kb(0, 3), 12, 1'b0, 4'hA};
    vecs[11] = '{kb(0, 0) | kb(3, 3), 48, 1'b1, 4'h1};
    vecs[12] = '{kb(0, 1), 48, 1'b1, 4'h2};
    vecs[13] = '{kb(2, 3), 48, 1'b1, 4'hC};
    col_seq[0] = 4'b1101;
    col_seq[1] = 4'b1011;
    col_seq[2] = 4'b0111;
    col_seq[3] = 4'b1110;

    // Reset values held for three cycles, then the column walk.
    RSTN = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("rst_col", 32'(COL_O), 32'h0000000E);
      chk("rst_key", 32'(KEY_O), 32'h0);
      chk("rst_entry", ENTRY_O, 32'h0);
      chk("rst_vld", 32'(KEY_VLD_O), 32'h0);
    end
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(4);
      chk("col_step", 32'(COL_O), 32'(col_seq[k]));
    end

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("first_entry", ENTRY_O, 32'h00000005);
      if (i == 9) chk("wrap_entry", ENTRY_O, 32'h23456789);
    end

    // Reset while a key is held in PRESSED, then re-report after two fresh scans.
    expect_key(4'h1);
    keys_down = kb(0, 0);
    tick(48);
    chk("held_reported", 32'(sb.size()), 32'h0);
    sb.delete();
    chk("held_state", 32'(dut.state), 32'(ST_PRESSED));
    RSTN = 1'b0;
    tick(3);
    chk("mid_rst_key", 32'(KEY_O), 32'h0);
    chk("mid_rst_entry", ENTRY_O, 32'h0);
    chk("mid_rst_col", 32'(COL_O), 32'h0000000E);
    chk("mid_rst_vld", 32'(KEY_VLD_O), 32'h0);
    chk("mid_rst_fsm", 32'(dut.state), 32'(ST_IDLE));
    m_entry = 32'h0;
    m_key = 4'h0;
    RSTN = 1'b1;
    rel = cyc;
    vld_cyc = 0;
    expect_key(4'h1);
    tick(48);
    chk("relatch_latency", 32'(vld_cyc - rel), 32'd33);
    keys_down = 16'h0;
    tick(56);
    settle_checks();

    for (int i = 12; i < 14; i++) begin
      run_vec(vecs[i]);
      if (i == 12) chk("pre_clear_entry", ENTRY_O, 32'h00000012);
    end
`ifdef KYPD_CLEAR_EN
    chk("final_entry", ENTRY_O, 32'h00000000);
`else
    chk("final_entry", ENTRY_O, 32'h0000012C);
`endif
    chk("final_key", 32'(KEY_O), 32'h0000000C);
    chk("pulse_count", 32'(seen), 32'(expected));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
